// File: rtl/dip_switch_ctrl_pkg.sv
// dip_switch_ctrl_pkg: CTRL bit layout and register map helpers
package dip_switch_ctrl_pkg;
  localparam int IRQ_EN_BIT = 0;
  localparam int PENDING_BIT = 1;
  function automatic int calc_nw(input int n_banks);
    return (n_banks + 3) / 4;
  endfunction
  function automatic int ctrl_addr(input int n_banks);
    return calc_nw(n_banks);
  endfunction
endpackage

// File: rtl/dip_switch_ctrl_if.sv
// dip_switch_ctrl_if: bridge-side register bus plus interrupt line
interface dip_switch_ctrl_if;
  logic [4:0] addr;
  logic we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic irq;
  modport master (output addr, we, wdata, input rdata, irq);
  modport slave (input addr, we, wdata, output rdata, irq);
endinterface

// File: rtl/dip_switch_ctrl_debounce.sv
// switch_debounce: synchronise and debounce one 8-bit switch bank
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic [7:0] sw,
  output logic [7:0] stable,
  output logic change
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [7:0] sync1_q, sync2_q, stable_q, stable_d, logical;
  logic [CW-1:0] cnt_q, cnt_d;
  assign logical = ACTIVE_LOW ? ~sync2_q : sync2_q;
  assign change = (logical != stable_q) && (cnt_q == LAST);
  assign stable = stable_q;
  // count consecutive cycles of disagreement; accept whatever value is present on the last one
  always_comb begin
    cnt_d = (logical == stable_q || change) ? '0 : cnt_q + 1'b1;
    stable_d = change ? logical : stable_q;
  end
  // two-flop synchroniser resets to the inactive raw level so reset reads as all-off
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= {8{ACTIVE_LOW}};
      sync2_q <= {8{ACTIVE_LOW}};
      stable_q <= '0;
      cnt_q <= '0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
      stable_q <= stable_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/dip_switch_ctrl.sv
// dip_switch_ctrl: debounced switch banks exposed as read words with a sticky change interrupt
module dip_switch_ctrl
  import dip_switch_ctrl_pkg::*;
#(
  parameter int N_BANKS = 8,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic [8*N_BANKS-1:0] sw_in,
  dip_switch_ctrl_if.slave bus
);
  localparam int NW = calc_nw(N_BANKS);
  localparam logic [4:0] CTRL_ADDR = 5'(ctrl_addr(N_BANKS));
  logic [32*NW-1:0] words;
  logic [N_BANKS-1:0] changes;
  logic [31:0] ctrl, rdata;
  logic irq_en_q, irq_en_d, pending_q, pending_d, ctrl_wr;
  logic unused_wdata;
  for (genvar b = 0; b < 4 * NW; b++) begin : g_bank
    if (b < N_BANKS) begin : g_real
      switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(ACTIVE_LOW)) u_db (
        .clk(clk),
        .reset(reset),
        .sw(sw_in[8*b+:8]),
        .stable(words[8*b+:8]),
        .change(changes[b])
      );
    end else begin : g_pad
      assign words[8*b+:8] = 8'h00;
    end
  end
  assign ctrl_wr = bus.we && bus.addr == CTRL_ADDR;
  assign unused_wdata = ^bus.wdata;
  // CTRL register: a bank acceptance wins over a same-edge clear
  always_comb begin
    ctrl = '0;
    ctrl[IRQ_EN_BIT] = irq_en_q;
    ctrl[PENDING_BIT] = pending_q;
    irq_en_d = ctrl_wr ? bus.wdata[IRQ_EN_BIT] : irq_en_q;
    pending_d = (|changes) | (pending_q & ~(ctrl_wr & bus.wdata[PENDING_BIT]));
  end
  // read mux: data words below CTRL, CTRL at NW, zero above
  always_comb begin
    rdata = bus.addr == CTRL_ADDR ? ctrl : 32'h0;
    for (int w = 0; w < NW; w++) rdata = bus.addr == 5'(w) ? words[32*w+:32] : rdata;
  end
  assign bus.rdata = rdata;
  assign bus.irq = pending_q & irq_en_q;
  // interrupt enable and sticky pending flag
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      pending_q <= pending_d;
    end
  end
endmodule

// File: tb/tb_dip_switch_ctrl.sv
// tb_dip_switch_ctrl: directed checks of debounce timing, packing and CTRL behaviour
module tb_dip_switch_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [47:0] sw_in = '1;
  int n_tests = 0;
  int n_fail = 0;
  dip_switch_ctrl_if bus();
  dip_switch_ctrl #(.N_BANKS(6), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk),
    .reset(reset),
    .sw_in(sw_in),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
    bus.addr = a;
    #1;
    check(tag, bus.rdata, exp);
  endtask
  task automatic irq_is(input string tag, input logic exp);
    check(tag, {31'b0, bus.irq}, {31'b0, exp});
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.addr = a;
    bus.wdata = d;
    bus.we = 1'b1;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
  endtask
  initial begin
    bus.addr = '0;
    bus.we = 1'b0;
    bus.wdata = '0;
    step(3);
    reset = 1'b0;
    rd(0, "reset_w0", 32'h0);
    rd(1, "reset_w1", 32'h0);
    rd(2, "reset_ctrl", 32'h0);
    irq_is("reset_irq", 1'b0);
    wr(2, 32'h1);
    rd(2, "irq_en_set", 32'h1);
    sw_in[7:0] = 8'hF0;
    bus.addr = 0;
    step(5);
    rd(0, "accept_edge5", 32'h0);
    irq_is("irq_edge5", 1'b0);
    step(1);
    rd(0, "accept_edge6", 32'h0000000F);
    irq_is("irq_edge6", 1'b1);
    rd(2, "ctrl_after_accept", 32'h3);
    wr(2, 32'h3);
    rd(2, "ctrl_cleared", 32'h1);
    irq_is("irq_cleared", 1'b0);
    sw_in[47:40] = 8'h00;
    step(3);
    sw_in[47:40] = 8'hFF;
    step(10);
    rd(1, "glitch_w1", 32'h0);
    rd(2, "glitch_ctrl", 32'h1);
    sw_in[39:32] = 8'hFE;
    sw_in[47:40] = 8'h7F;
    step(8);
    rd(1, "pack_w1", 32'h00008001);
    rd(0, "pack_w0", 32'h0000000F);
    rd(2, "pack_ctrl", 32'h3);
    rd(3, "pack_oor", 32'h0);
    wr(2, 32'h3);
    sw_in[15:8] = 8'h0F;
    step(5);
    wr(2, 32'h2);
    rd(2, "collide_ctrl", 32'h2);
    rd(0, "collide_w0", 32'h0000F00F);
    irq_is("collide_irq", 1'b0);
    wr(2, 32'h2);
    rd(2, "mask_cleared", 32'h0);
    sw_in[23:16] = 8'h00;
    step(6);
    rd(2, "mask_pending", 32'h2);
    irq_is("mask_irq_off", 1'b0);
    rd(0, "mask_w0", 32'h00FFF00F);
    wr(2, 32'h1);
    irq_is("mask_irq_on", 1'b1);
    rd(2, "mask_ctrl", 32'h3);
    wr(2, 32'h3);
    rd(2, "mask_clr", 32'h1);
    sw_in[31:24] = 8'hAA;
    step(4);
    reset = 1'b1;
    sw_in = '1;
    step(2);
    reset = 1'b0;
    step(8);
    rd(0, "rst_mid_w0", 32'h0);
    rd(1, "rst_mid_w1", 32'h0);
    rd(2, "rst_mid_ctrl", 32'h0);
    irq_is("rst_mid_irq", 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
